// File: rtl/bayer_line_buffer_pkg.sv
// Shared constants, pixel type and width helper for the Bayer line buffer.
// Optional build macro: BAYER_LB_BORDER_REPLICATE_EN (see bayer_line_buffer.sv).
package bayer_line_buffer_pkg;

   localparam int DATA_W_DEF   = 10;
   localparam int IMG_W_DEF    = 640;
   localparam int LINE_CNT_MAX = 2;

   typedef logic [DATA_W_DEF-1:0] pixel_t;

   function automatic int col_w(input int img_w);
      return (img_w > 1) ? $clog2(img_w) : 1;
   endfunction

endpackage

// File: rtl/bayer_line_buffer_if.sv
// Pixel stream in / vertical tap triple out, shared by the line buffer and its feeder.
// Optional build macro: BAYER_LB_BORDER_REPLICATE_EN (affects only the module, not this bundle).
interface bayer_line_buffer_if #(
   parameter int DATA_W = bayer_line_buffer_pkg::DATA_W_DEF,
   parameter int IMG_W  = bayer_line_buffer_pkg::IMG_W_DEF
);
   import bayer_line_buffer_pkg::*;

   localparam int COL_W = col_w(IMG_W);

   logic [DATA_W-1:0] pix_in;
   logic              pix_valid;
   logic              pix_sof;
   logic              pix_eol;
   logic [DATA_W-1:0] tap_top;
   logic [DATA_W-1:0] tap_mid;
   logic [DATA_W-1:0] tap_bot;
   logic              tap_valid;
   logic [COL_W-1:0]  tap_col;
   logic              tap_sol;
   logic              err_overrun;

   modport master (
      output pix_in, pix_valid, pix_sof, pix_eol,
      input  tap_top, tap_mid, tap_bot, tap_valid, tap_col, tap_sol, err_overrun
   );

   modport slave (
      input  pix_in, pix_valid, pix_sof, pix_eol,
      output tap_top, tap_mid, tap_bot, tap_valid, tap_col, tap_sol, err_overrun
   );

endinterface

// File: rtl/bayer_line_buffer_line_ram.sv
// Simple dual-port line RAM, registered read, read-before-write on a shared address.
// Optional build macro: BAYER_LB_BORDER_REPLICATE_EN (not used here).
module bayer_line_buffer_line_ram #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 640,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read register is cleared so the taps read zero straight after reset
   always_ff @(posedge clk) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/bayer_line_buffer.sv
// Raster Bayer stream to three vertically aligned row taps (two stored lines + current).
// Optional build macro: BAYER_LB_BORDER_REPLICATE_EN enables taps on lines 0/1 with row replication.
module bayer_line_buffer
   import bayer_line_buffer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IMG_W  = IMG_W_DEF
) (
   input logic               clk,
   input logic               rst_n,
   bayer_line_buffer_if.slave bus
);

   localparam int               COL_W    = col_w(IMG_W);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

   function automatic logic [1:0] line_inc_sat(input logic [1:0] lc);
      return (lc >= 2'(LINE_CNT_MAX)) ? 2'(LINE_CNT_MAX) : lc + 2'd1;
   endfunction

   logic [COL_W-1:0]  col_cnt;
   logic [1:0]        line_cnt;
   logic              err_q;

   logic              vld_p0, eol_p0, ovr_p0, tap_ok_p0;
   logic [COL_W-1:0]  col_p0;
   logic [1:0]        lc_p0;

   logic              acc_p1, vld_p1, sol_p1, hit_p1;
   logic [COL_W-1:0]  col_p1;
   logic [DATA_W-1:0] bot_p1, byp_p1, rd_a, rd_b, top_std;

   // ---- stage p0: accept, resolve column/line after sof ----
   always_comb begin
      vld_p0 = bus.pix_valid;
      col_p0 = bus.pix_sof ? '0 : col_cnt;
      lc_p0  = bus.pix_sof ? 2'd0 : line_cnt;
      ovr_p0 = (col_p0 == COL_LAST) && !bus.pix_eol;
      eol_p0 = bus.pix_eol || (col_p0 == COL_LAST);
`ifdef BAYER_LB_BORDER_REPLICATE_EN
      tap_ok_p0 = 1'b1;
`else
      tap_ok_p0 = (lc_p0 == 2'(LINE_CNT_MAX));
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_cnt  <= '0;
         line_cnt <= 2'd0;
         err_q    <= 1'b0;
      end else if (vld_p0) begin
         col_cnt  <= eol_p0 ? '0 : col_p0 + 1'b1;
         line_cnt <= eol_p0 ? line_inc_sat(lc_p0) : lc_p0;
         err_q    <= (err_q && !bus.pix_sof) || ovr_p0;
      end
   end

   // mem_b holds the previous line; mem_a is refilled from mem_b's old word one cycle later
   bayer_line_buffer_line_ram #(.DATA_W(DATA_W), .DEPTH(IMG_W), .ADDR_W(COL_W)) u_mem_b (
      .clk(clk), .rst_n(rst_n),
      .rd_en(vld_p0), .rd_addr(col_p0), .rd_data(rd_b),
      .wr_en(vld_p0), .wr_addr(col_p0), .wr_data(bus.pix_in)
   );

   bayer_line_buffer_line_ram #(.DATA_W(DATA_W), .DEPTH(IMG_W), .ADDR_W(COL_W)) u_mem_a (
      .clk(clk), .rst_n(rst_n),
      .rd_en(vld_p0), .rd_addr(col_p0), .rd_data(rd_a),
      .wr_en(acc_p1), .wr_addr(col_p1), .wr_data(rd_b)
   );

   // ---- stage p1: tap alignment registers ----
   // hit_p1 covers a one-pixel line, where the delayed mem_a write lands on the address being read
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_p1 <= 1'b0;
         vld_p1 <= 1'b0;
         col_p1 <= '0;
         sol_p1 <= 1'b0;
         bot_p1 <= '0;
         hit_p1 <= 1'b0;
         byp_p1 <= '0;
      end else begin
         acc_p1 <= vld_p0;
         vld_p1 <= vld_p0 && tap_ok_p0;
         if (vld_p0) begin
            col_p1 <= col_p0;
            sol_p1 <= (col_p0 == '0);
            bot_p1 <= bus.pix_in;
            hit_p1 <= acc_p1 && (col_p1 == col_p0);
            byp_p1 <= rd_b;
         end
      end
   end

   assign top_std = hit_p1 ? byp_p1 : rd_a;

`ifdef BAYER_LB_BORDER_REPLICATE_EN
   logic [1:0] lc_p1;

   always_ff @(posedge clk) begin
      if (!rst_n)      lc_p1 <= 2'd0;
      else if (vld_p0) lc_p1 <= lc_p0;
   end

   always_comb begin
      bus.tap_top = top_std;
      bus.tap_mid = rd_b;
      case (lc_p1)
         2'd0: begin
            bus.tap_top = bot_p1;
            bus.tap_mid = bot_p1;
         end
         2'd1: begin
            bus.tap_top = rd_b;
            bus.tap_mid = rd_b;
         end
         default: ;
      endcase
   end
`else
   always_comb begin
      bus.tap_top = top_std;
      bus.tap_mid = rd_b;
   end
`endif

   assign bus.tap_bot     = bot_p1;
   assign bus.tap_valid   = vld_p1;
   assign bus.tap_col     = col_p1;
   assign bus.tap_sol     = sol_p1;
   assign bus.err_overrun = err_q;

endmodule

// File: tb/tb_bayer_line_buffer.sv
// Directed bench for bayer_line_buffer: image-level model plus literal spot checks.
// Build with BAYER_LB_BORDER_REPLICATE_EN to exercise the border replication variant.
module tb_bayer_line_buffer;
   import bayer_line_buffer_pkg::*;

   localparam int DW = 10;
   localparam int IW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bayer_line_buffer_if #(.DATA_W(DW), .IMG_W(IW)) bus ();

   bayer_line_buffer #(.DATA_W(DW), .IMG_W(IW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   // Image model: rows of the current frame as written, indexed by true row number
   logic [DW-1:0] frame [0:63][0:IW-1];
   int  mrow, mcol;
   bit  merr;
   bit  e_valid, e_sol, e_known;
   logic [DW-1:0] e_top, e_mid, e_bot;
   int  e_col;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_step(input bit v, input logic [DW-1:0] p, input bit sof, input bit eol);
      int c, r;
      if (!v) begin
         e_valid = 1'b0;
         return;
      end
      if (sof) begin
         mrow = 0;
         mcol = 0;
         merr = 1'b0;
      end
      c = mcol;
      r = mrow;
      frame[r][c] = p;
      e_bot = p;
      e_col = c;
      e_sol = (c == 0);
`ifdef BAYER_LB_BORDER_REPLICATE_EN
      e_valid = 1'b1;
      e_known = 1'b1;
      if (r == 0) begin
         e_top = p;
         e_mid = p;
      end else if (r == 1) begin
         e_top = frame[0][c];
         e_mid = frame[0][c];
      end else begin
         e_top = frame[r-2][c];
         e_mid = frame[r-1][c];
      end
`else
      e_valid = (r >= 2);
      e_known = e_valid;
      if (e_valid) begin
         e_top = frame[r-2][c];
         e_mid = frame[r-1][c];
      end
`endif
      if (c == IW - 1 && !eol) merr = 1'b1;
      if (eol || c == IW - 1) begin
         mcol = 0;
         if (mrow < 63) mrow++;
      end else begin
         mcol++;
      end
   endtask

   task automatic drive(input bit v, input logic [DW-1:0] p, input bit sof, input bit eol);
      @(negedge clk);
      bus.pix_valid = v;
      bus.pix_in    = p;
      bus.pix_sof   = sof;
      bus.pix_eol   = eol;
      @(posedge clk);
      #1;
      model_step(v, p, sof, eol);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.pix_valid = 1'b0;
      bus.pix_sof = 1'b0;
      bus.pix_eol = 1'b0;
      @(posedge clk);
      #1;
      mrow = 0; mcol = 0; merr = 1'b0;
      e_valid = 1'b0; e_known = 1'b1;
      e_top = '0; e_mid = '0; e_bot = '0; e_col = 0; e_sol = 1'b0;
      check("rst_valid", bus.tap_valid, 0);
      check("rst_err", bus.err_overrun, 0);
      check("rst_top", bus.tap_top, 0);
      check("rst_mid", bus.tap_mid, 0);
      check("rst_bot", bus.tap_bot, 0);
      check("rst_col", bus.tap_col, 0);
      check("rst_sol", bus.tap_sol, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Per-cycle comparison against the image model
   always @(negedge clk) begin
      if (chk_on) begin
         check("cyc_valid", bus.tap_valid, e_valid);
         check("cyc_err", bus.err_overrun, merr);
         check("cyc_bot", bus.tap_bot, e_bot);
         check("cyc_col", bus.tap_col, e_col);
         check("cyc_sol", bus.tap_sol, e_sol);
         if (e_known) begin
            check("cyc_top", bus.tap_top, e_top);
            check("cyc_mid", bus.tap_mid, e_mid);
         end
      end
   end

   // Three lines of row*16+col; optional idle cycle after every pixel
   task automatic run_frame3(input bit gaps);
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < IW; c++) begin
            drive(1'b1, DW'(r * 16 + c), (r == 0 && c == 0), (c == IW - 1));
            if (r == 2 && c == 0) begin
               check("f3_c0_valid", bus.tap_valid, 1);
               check("f3_c0_top", bus.tap_top, 'h00);
               check("f3_c0_mid", bus.tap_mid, 'h10);
               check("f3_c0_bot", bus.tap_bot, 'h20);
               check("f3_c0_sol", bus.tap_sol, 1);
            end
            if (r == 2 && c == IW - 1) begin
               check("f3_c7_top", bus.tap_top, 'h07);
               check("f3_c7_mid", bus.tap_mid, 'h17);
               check("f3_c7_bot", bus.tap_bot, 'h27);
               check("f3_c7_col", bus.tap_col, 7);
            end
`ifdef BAYER_LB_BORDER_REPLICATE_EN
            if (r == 1 && c == 0) begin
               check("br_l1_valid", bus.tap_valid, 1);
               check("br_l1_top", bus.tap_top, 'h00);
               check("br_l1_mid", bus.tap_mid, 'h00);
               check("br_l1_bot", bus.tap_bot, 'h10);
            end
`endif
            if (gaps) begin
               drive(1'b0, DW'('h3AA), 1'b0, 1'b0);
               if (r == 2 && c == IW - 1) begin
                  check("gap_valid", bus.tap_valid, 0);
                  check("gap_bot_hold", bus.tap_bot, 'h27);
                  check("gap_top_hold", bus.tap_top, 'h07);
               end
            end
         end
      end
      drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      int nv;
      bus.pix_in = '0;
      bus.pix_valid = 1'b0;
      bus.pix_sof = 1'b0;
      bus.pix_eol = 1'b0;
      e_known = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();
      chk_on = 1'b1;

`ifdef BAYER_LB_BORDER_REPLICATE_EN
      drive(1'b1, DW'('h05), 1'b1, 1'b0);
      check("br_l0_valid", bus.tap_valid, 1);
      check("br_l0_top", bus.tap_top, 'h05);
      check("br_l0_mid", bus.tap_mid, 'h05);
      check("br_l0_bot", bus.tap_bot, 'h05);
      drive(1'b0, '0, 1'b0, 1'b0);
`endif

      run_frame3(1'b0);
      run_frame3(1'b1);

      // Overrun: ten pixels, no eol
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, DW'('h100 + i), (i == 0), 1'b0);
         if (i == 6) check("ovr_err_before", bus.err_overrun, 0);
         if (i == 7) check("ovr_err_set", bus.err_overrun, 1);
         if (i == 8) begin
            check("ovr_col_wrap", bus.tap_col, 0);
            check("ovr_err_held", bus.err_overrun, 1);
         end
      end
      drive(1'b1, DW'('h3FF), 1'b1, 1'b0);
      check("ovr_sof_clear", bus.err_overrun, 0);
      drive(1'b0, '0, 1'b0, 1'b0);

      // sof in the middle of line 3 restarts the line count
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < IW; c++)
            drive(1'b1, DW'(r * 16 + c), (r == 0 && c == 0), (c == IW - 1));
      for (int c = 0; c < 3; c++)
         drive(1'b1, DW'('h30 + c), 1'b0, 1'b0);
      nv = 0;
      for (int r = 5; r < 7; r++) begin
         for (int c = 0; c < IW; c++) begin
            drive(1'b1, DW'(r * 16 + c), (r == 5 && c == 0), (c == IW - 1));
            nv += int'(bus.tap_valid);
         end
      end
`ifdef BAYER_LB_BORDER_REPLICATE_EN
      check("sof_mid_valid_cnt", nv, 16);
`else
      check("sof_mid_valid_cnt", nv, 0);
`endif
      drive(1'b1, DW'('h70), 1'b0, 1'b0);
      check("sof_mid_new_valid", bus.tap_valid, 1);
      check("sof_mid_new_top", bus.tap_top, 'h50);
      check("sof_mid_new_mid", bus.tap_mid, 'h60);
      check("sof_mid_new_bot", bus.tap_bot, 'h70);
      drive(1'b0, '0, 1'b0, 1'b0);

      // Reset in the middle of a line, then a clean frame
      for (int c = 0; c < 3; c++)
         drive(1'b1, DW'('h40 + c), (c == 0), 1'b0);
      do_reset();
      run_frame3(1'b0);

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
